// File: rtl/gbe_tx_arb.sv
// Three-source frame arbiter for the MAC TX byte port: one whole frame per grant, MAX_BYTES truncation, IFG spacing.
// Grant lands one cycle after a request in IDLE; the first byte holds until mac_tx_ack, and each following byte is sent and consumed in a single cycle.
module gbe_tx_arb #(
  parameter int MAX_BYTES  = 2048,
  parameter int IFG_CYCLES = 2
) (
  input  logic        mac_clk,
  input  logic        mac_rst_n,
  input  logic        arb_mode,
  input  logic [2:0]  src_req,
  input  logic [23:0] src_data,
  input  logic [2:0]  src_eof,
  output logic [2:0]  src_rd,
  output logic [2:0]  src_grant,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack,
  output logic [2:0]  frame_done,
  output logic        frame_abort
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_ACK, S_STREAM, S_DRAIN, S_GAP} state_t;

  localparam int          MAX_CLAMP = (MAX_BYTES > 4095) ? 4095 : MAX_BYTES;
  localparam logic [11:0] MAX_CNT   = 12'(MAX_CLAMP);
  localparam logic [4:0]  IFG       = 5'(IFG_CYCLES);

  state_t      state, state_nxt;
  logic [2:0]  grant;
  logic [1:0]  last;
  logic [11:0] byte_cnt;
  logic [11:0] cnt_inc;
  logic [3:0]  gap_cnt;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        cur_eof;
  logic        cnt_max;
  logic        gap_end;

  // Round-robin scans last+1, last+2, last+3 (mod 3); going downward lets the nearest candidate win.
  always_comb begin
    win_idx = 2'd0;
    cand    = 2'd0;
    if (arb_mode) begin
      for (int i = 3; i >= 1; i--) begin
        cand = 2'((int'(last) + i) % 3);
        if (src_req[cand]) win_idx = cand;
      end
    end else if (src_req[2]) begin
      win_idx = 2'd2;
    end else if (src_req[1]) begin
      win_idx = 2'd1;
    end
  end

  assign cur_eof   = |(src_eof & grant);
  assign cnt_inc   = (byte_cnt == 12'hFFF) ? byte_cnt : byte_cnt + 12'd1;
  assign cnt_max   = (cnt_inc >= MAX_CNT);
  assign gap_end   = (({1'b0, gap_cnt} + 5'd1) >= IFG);
  assign src_grant = grant;

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (|src_req) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (mac_tx_ack) begin
          if (cur_eof)                state_nxt = S_GAP;
          else if (MAX_CNT <= 12'd1)  state_nxt = S_DRAIN;
          else                        state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (cur_eof)      state_nxt = S_GAP;
        else if (cnt_max) state_nxt = S_DRAIN;
      end
      S_DRAIN:    if (cur_eof) state_nxt = S_GAP;
      S_GAP:      if (gap_end) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mac_tx_dvld = 1'b0;
    src_rd      = 3'b000;
    case (state)
      S_WAIT_ACK: begin
        mac_tx_dvld = 1'b1;
        if (mac_tx_ack) src_rd = grant;
      end
      S_STREAM: begin
        mac_tx_dvld = 1'b1;
        src_rd      = grant;
      end
      S_DRAIN:  src_rd = grant;
      default:  ;
    endcase
  end

  always_comb begin
    mac_tx_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) mac_tx_data = src_data[8*i +: 8];
    end
  end

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      grant       <= 3'b000;
      last        <= 2'd0;
      byte_cnt    <= 12'd0;
      gap_cnt     <= 4'd0;
      frame_done  <= 3'b000;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 3'b000;
      frame_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|src_req) begin
            grant <= 3'b001 << win_idx;
            // Fixed-priority grants leave the round-robin pointer untouched.
            if (arb_mode) last <= win_idx;
          end
        end
        S_WAIT_ACK: if (mac_tx_ack) byte_cnt <= 12'd1;
        S_STREAM:   byte_cnt <= cnt_inc;
        S_GAP:      gap_cnt <= gap_cnt + 4'd1;
        default:    ;
      endcase
      if (state != S_GAP && state_nxt == S_GAP) begin
        grant   <= 3'b000;
        gap_cnt <= 4'd0;
        if (state != S_DRAIN) frame_done <= grant;
      end
      if (state != S_DRAIN && state_nxt == S_DRAIN) frame_abort <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gbe_tx_arb.sv
// Directed bench for gbe_tx_arb: a scenario table of frames plus hand-written reset and ack-stall sequences.
module tb_gbe_tx_arb;
  localparam int IFG = 2;

  logic        mac_clk   = 1'b0;
  logic        mac_rst_n = 1'b0;
  logic        arb_mode  = 1'b0;
  logic        mac_tx_ack = 1'b0;
  logic        sel = 1'b0;
  logic        ld  = 1'b0;
  logic [2:0][11:0] ld_len = '0;
  logic [2:0][7:0]  ld_cnt = '0;

  logic [2:0]  src_req, src_eof;
  logic [23:0] src_data;
  logic [2:0]  rd_a, rd_b, grant_a, grant_b, done_a, done_b;
  logic [7:0]  data_a, data_b;
  logic        dvld_a, dvld_b, abort_a, abort_b;
  logic [2:0]  rd, grant, done;
  logic [7:0]  data;
  logic        dvld, abort;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 mac_clk = ~mac_clk;

  gbe_tx_arb #(.MAX_BYTES(2048), .IFG_CYCLES(IFG)) dut (
    .mac_clk(mac_clk), .mac_rst_n(mac_rst_n), .arb_mode(arb_mode),
    .src_req(src_req), .src_data(src_data), .src_eof(src_eof),
    .src_rd(rd_a), .src_grant(grant_a), .mac_tx_data(data_a),
    .mac_tx_dvld(dvld_a), .mac_tx_ack(mac_tx_ack),
    .frame_done(done_a), .frame_abort(abort_a)
  );

  gbe_tx_arb #(.MAX_BYTES(16), .IFG_CYCLES(IFG)) dut_trunc (
    .mac_clk(mac_clk), .mac_rst_n(mac_rst_n), .arb_mode(arb_mode),
    .src_req(src_req), .src_data(src_data), .src_eof(src_eof),
    .src_rd(rd_b), .src_grant(grant_b), .mac_tx_data(data_b),
    .mac_tx_dvld(dvld_b), .mac_tx_ack(mac_tx_ack),
    .frame_done(done_b), .frame_abort(abort_b)
  );

  assign rd    = sel ? rd_b    : rd_a;
  assign grant = sel ? grant_b : grant_a;
  assign done  = sel ? done_b  : done_a;
  assign data  = sel ? data_b  : data_a;
  assign dvld  = sel ? dvld_b  : dvld_a;
  assign abort = sel ? abort_b : abort_a;

  // Source model: FWFT frame buffers; byte value = src*64 + position within frame.
  logic [11:0] pos  [3];
  logic [11:0] len  [3];
  logic [7:0]  left [3];

  always @(posedge mac_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ld) begin
        pos[i]  <= 12'd0;
        len[i]  <= ld_len[i];
        left[i] <= ld_cnt[i];
      end else if (rd[i] && left[i] != 8'd0) begin
        if (pos[i] == len[i] - 12'd1) begin
          pos[i]  <= 12'd0;
          left[i] <= left[i] - 8'd1;
        end else begin
          pos[i] <= pos[i] + 12'd1;
        end
      end
    end
  end

  always_comb begin
    src_req  = 3'b000;
    src_eof  = 3'b000;
    src_data = 24'd0;
    for (int i = 0; i < 3; i++) begin
      src_req[i] = (left[i] != 8'd0);
      src_eof[i] = (left[i] != 8'd0) && (pos[i] == len[i] - 12'd1);
      src_data[8*i +: 8] = 8'(i * 64) + pos[i][7:0];
    end
  end

  typedef struct packed {
    logic             mode;
    logic             sel;
    logic [2:0][11:0] len;
    logic [2:0][7:0]  cnt;
    logic [2:0]       nfr;
    logic [3:0][1:0]  src;
    logic [3:0][11:0] sent;
    logic [3:0][11:0] rds;
    logic [3:0]       abort;
    logic [3:0][7:0]  ack_dly;
  } vec_t;

  vec_t vec [6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_sc(input int v, input logic md, input logic sl,
                        input logic [2:0][11:0] l, input logic [2:0][7:0] c, input int nf);
    vec[v]      = '0;
    vec[v].mode = md;
    vec[v].sel  = sl;
    vec[v].len  = l;
    vec[v].cnt  = c;
    vec[v].nfr  = 3'(nf);
  endtask

  task automatic set_fr(input int v, input int f, input int s, input int snt,
                        input int r, input logic ab, input int dly);
    vec[v].src[f]     = 2'(s);
    vec[v].sent[f]    = 12'(snt);
    vec[v].rds[f]     = 12'(r);
    vec[v].abort[f]   = ab;
    vec[v].ack_dly[f] = 8'(dly);
  endtask

  task automatic do_reset(input logic [2:0][11:0] l, input logic [2:0][7:0] c);
    @(negedge mac_clk);
    mac_rst_n  = 1'b0;
    mac_tx_ack = 1'b0;
    ld_len = l;
    ld_cnt = c;
    ld     = 1'b1;
    #1;
    chk("reset_outputs", {grant, rd, dvld, data, done, abort}, 0);
    @(negedge mac_clk);
    ld = 1'b0;
    @(negedge mac_clk);
    mac_rst_n = 1'b1;
  endtask

  task automatic run_frame(input int s, input int sent, input int rds, input logic ab,
                           input int dly, input int exp_wait, input logic late);
    int n, k, nrd, nab, bad;
    logic [7:0] b0;
    n = 0;
    while (grant == 3'b000 && n < 300) begin
      @(negedge mac_clk);
      n++;
    end
    chk("grant_wait", n, exp_wait);
    chk("grant", grant, 3'b001 << s);
    chk("dvld_on_grant", dvld, 1);
    b0  = 8'(s * 64);
    bad = 0;
    for (int i = 0; i < dly; i++) begin
      ld = late && (i == dly / 2);
      if (rd != 3'b000 || data != b0 || dvld != 1'b1 || grant != (3'b001 << s)) bad++;
      @(negedge mac_clk);
    end
    ld = 1'b0;
    if (dly > 0) chk("ack_stall", bad, 0);
    mac_tx_ack = 1'b1;
    #1;
    chk("first_byte", data, b0);
    chk("rd_on_ack", rd, 3'b001 << s);
    @(negedge mac_clk);
    mac_tx_ack = 1'b0;
    k = 1; nrd = 1; nab = 0; bad = 0; n = 0;
    while (grant != 3'b000 && n < 5000) begin
      if (dvld) begin
        if (k >= sent || data != 8'(s * 64 + k)) bad++;
        k++;
      end
      if (rd != 3'b000) begin
        if (rd != (3'b001 << s)) bad++;
        nrd++;
      end
      if (abort) nab++;
      if (done != 3'b000) bad++;
      @(negedge mac_clk);
      n++;
    end
    chk("frame_end_seen", (n < 5000) ? 1 : 0, 1);
    chk("bytes_sent", k, sent);
    chk("byte_data", bad, 0);
    chk("rd_count", nrd, rds);
    chk("dvld_off_end", dvld, 0);
    chk("frame_done", done, ab ? 0 : (3'b001 << s));
    chk("frame_abort", nab + int'(abort), ab ? 1 : 0);
    @(negedge mac_clk);
    chk("pulse_width", {done, abort}, 0);
  endtask

  initial begin
    int n;
    // Scenario table: {mode, instance, lengths {s2,s1,s0}, frame counts} then per-frame expectations.
    set_sc(0, 1'b0, 1'b0, {12'd0, 12'd0, 12'd64}, {8'd0, 8'd0, 8'd1}, 1);
    set_fr(0, 0, 0, 64, 64, 1'b0, 3);
    set_sc(1, 1'b0, 1'b0, {12'd10, 12'd10, 12'd10}, {8'd1, 8'd1, 8'd1}, 3);
    set_fr(1, 0, 2, 10, 10, 1'b0, 0);
    set_fr(1, 1, 1, 10, 10, 1'b0, 1);
    set_fr(1, 2, 0, 10, 10, 1'b0, 2);
    set_sc(2, 1'b1, 1'b0, {12'd1, 12'd1, 12'd1}, {8'd100, 8'd100, 8'd100}, 4);
    set_fr(2, 0, 1, 1, 1, 1'b0, 0);
    set_fr(2, 1, 2, 1, 1, 1'b0, 0);
    set_fr(2, 2, 0, 1, 1, 1'b0, 0);
    set_fr(2, 3, 1, 1, 1, 1'b0, 0);
    set_sc(3, 1'b0, 1'b1, {12'd0, 12'd20, 12'd0}, {8'd0, 8'd1, 8'd0}, 1);
    set_fr(3, 0, 1, 16, 20, 1'b1, 0);
    set_sc(4, 1'b0, 1'b1, {12'd16, 12'd0, 12'd0}, {8'd1, 8'd0, 8'd0}, 1);
    set_fr(4, 0, 2, 16, 16, 1'b0, 1);
    set_sc(5, 1'b0, 1'b0, {12'd0, 12'd2, 12'd3}, {8'd0, 8'd2, 8'd1}, 3);
    set_fr(5, 0, 1, 2, 2, 1'b0, 0);
    set_fr(5, 1, 1, 2, 2, 1'b0, 1);
    set_fr(5, 2, 0, 3, 3, 1'b0, 0);

    for (int v = 0; v < 6; v++) begin
      arb_mode = vec[v].mode;
      sel      = vec[v].sel;
      do_reset(vec[v].len, vec[v].cnt);
      for (int f = 0; f < int'(vec[v].nfr); f++) begin
        run_frame(int'(vec[v].src[f]), int'(vec[v].sent[f]), int'(vec[v].rds[f]),
                  vec[v].abort[f], int'(vec[v].ack_dly[f]), (f == 0) ? 1 : IFG, 1'b0);
      end
    end

    // Reset in the middle of a 30-byte frame, then only src0 requests.
    arb_mode = 1'b0;
    sel      = 1'b0;
    do_reset({12'd0, 12'd0, 12'd30}, {8'd0, 8'd0, 8'd1});
    n = 0;
    while (grant == 3'b000 && n < 300) begin
      @(negedge mac_clk);
      n++;
    end
    chk("mid_grant_wait", n, 1);
    mac_tx_ack = 1'b1;
    @(negedge mac_clk);
    mac_tx_ack = 1'b0;
    repeat (4) @(negedge mac_clk);
    chk("pre_reset_byte", data, 5);
    mac_rst_n = 1'b0;
    ld_len = {12'd0, 12'd0, 12'd3};
    ld_cnt = {8'd0, 8'd0, 8'd1};
    ld     = 1'b1;
    #1;
    chk("reset_midframe", {dvld, rd, grant}, 0);
    @(negedge mac_clk);
    ld        = 1'b0;
    mac_rst_n = 1'b1;
    @(negedge mac_clk);
    chk("regrant_after_reset", grant, 3'b001);
    chk("redvld_after_reset", dvld, 1);
    chk("restart_byte", data, 0);

    // Long ack stall; src2 starts requesting halfway through and must not preempt.
    do_reset({12'd0, 12'd0, 12'd4}, {8'd0, 8'd0, 8'd1});
    ld_len = {12'd2, 12'd0, 12'd4};
    ld_cnt = {8'd1, 8'd0, 8'd1};
    run_frame(0, 4, 4, 1'b0, 100, 1, 1'b1);
    run_frame(2, 2, 2, 1'b0, 0, IFG, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
